// File: rtl/noc_port_rr_arbiter.sv
// noc_port_rr_arbiter
//   Round-robin, packet-locking arbiter for one router output port. The port
//   is granted to one input-port requester at a time and held from head flit
//   through tail flit. Arbitration searches from a rotating pointer that moves
//   past the previous owner after each completed packet.
//
// Build option:
//   OPA_CREDIT_EN  defined   -> downstream credit counter gates transfers
//                              (ports credit_in, credits, cred_err present)
//                  undefined -> out_ready input gates transfers
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   req        in   N   requester i presents a flit
//   tail       in   N   flit presented by requester i is a tail flit
//   gnt        out  N   registered one-hot (or zero) owner, crossbar select
//   fire       out  1   combinational, a flit transfers this cycle
//   busy       out  1   registered, port locked to an owner
//   credit_in  in   1   (OPA_CREDIT_EN) downstream freed one slot
//   credits    out  CW  (OPA_CREDIT_EN) registered free-slot count
//   cred_err   out  1   (OPA_CREDIT_EN) sticky credit-overflow flag
//   out_ready  in   1   (no OPA_CREDIT_EN) downstream accepts a flit

module noc_port_rr_arbiter #(
    parameter int N       = 5,
    parameter int CREDITS = 4,
    parameter int CW      = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  tail,
    output logic [N-1:0]  gnt,
    output logic          fire,
    output logic          busy,
`ifdef OPA_CREDIT_EN
    input  logic          credit_in,
    output logic [CW-1:0] credits,
    output logic          cred_err
`else
    input  logic          out_ready
`endif
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_ptr;
    logic [N-1:0]  r_gnt;
    logic          r_busy;

    logic          w_can_send;
    logic          w_fire;
    logic          w_tail_fire;
    logic          w_win_valid;
    logic [PW-1:0] w_win_idx;
    logic [PW:0]   w_dist;
    logic [PW:0]   w_best;
    logic [N-1:0]  w_win_onehot;
    logic [PW-1:0] w_owner_idx;
    logic [PW-1:0] w_ptr_next;

    // Winner = requester with the smallest rotational distance from r_ptr.
    // Distance is computed per absolute index so every select is static.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        w_best      = (PW+1)'(N);
        w_dist      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (PW'(i) >= r_ptr)
                w_dist = (PW+1)'(i) - {1'b0, r_ptr};
            else
                w_dist = (PW+1)'(i) + (PW+1)'(N) - {1'b0, r_ptr};
            if (req[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_win_idx   = PW'(i);
                w_win_valid = 1'b1;
            end
        end
    end

    assign w_win_onehot = N'(1) << w_win_idx;

    always_comb begin
        w_owner_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (r_gnt[i])
                w_owner_idx = PW'(i);
        end
    end

    assign w_ptr_next = (w_owner_idx == PW'(N-1)) ? '0 : w_owner_idx + PW'(1);

    // r_gnt is zero while idle and one-hot while locked, so masking req/tail
    // with it selects the owner's bits and ignores everyone else.
    assign w_fire      = (|(r_gnt & req)) & w_can_send;
    assign w_tail_fire = w_fire & (|(r_gnt & tail));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_win_valid) begin
                        r_gnt   <= w_win_onehot;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_tail_fire) begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= w_ptr_next;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef OPA_CREDIT_EN
    logic [CW-1:0] r_credits;
    logic          r_cred_err;

    assign w_can_send = (r_credits != '0);

    // Simultaneous fire and credit_in cancel. A return with the counter
    // already full is an overflow: count saturates and the flag sticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credits  <= CW'(CREDITS);
            r_cred_err <= 1'b0;
        end else begin
            case ({w_fire, credit_in})
                2'b10: r_credits <= r_credits - CW'(1);
                2'b01: begin
                    if (r_credits == CW'(CREDITS))
                        r_cred_err <= 1'b1;
                    else
                        r_credits <= r_credits + CW'(1);
                end
                default: r_credits <= r_credits;
            endcase
        end
    end

    assign credits  = r_credits;
    assign cred_err = r_cred_err;
`else
    assign w_can_send = out_ready;
`endif

    assign gnt  = r_gnt;
    assign busy = r_busy;
    assign fire = w_fire;

endmodule

// File: tb/tb_noc_port_rr_arbiter.sv
module tb_noc_port_rr_arbiter;

    localparam int N       = 5;
    localparam int CREDITS = 4;
    localparam int CW      = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  tail = '0;
    logic [N-1:0]  gnt;
    logic          fire;
    logic          busy;
`ifdef OPA_CREDIT_EN
    logic          credit_in = 1'b0;
    logic [CW-1:0] credits;
    logic          cred_err;
`else
    logic          out_ready = 1'b1;
`endif

    noc_port_rr_arbiter #(.N(N), .CREDITS(CREDITS), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .tail      (tail),
        .gnt       (gnt),
        .fire      (fire),
        .busy      (busy),
`ifdef OPA_CREDIT_EN
        .credit_in (credit_in),
        .credits   (credits),
        .cred_err  (cred_err)
`else
        .out_ready (out_ready)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: owner index (-1 when idle), search pointer, credits.
    int m_owner;
    int m_ptr;
    int m_cred;
    bit m_err;
    bit cur_ci;
    bit cur_ordy;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_can_send();
`ifdef OPA_CREDIT_EN
        return m_cred != 0;
`else
        return cur_ordy;
`endif
    endfunction

    function automatic bit m_fire_now();
        return (m_owner >= 0) && req[m_owner] && m_can_send();
    endfunction

    function automatic int m_gnt();
        return (m_owner >= 0) ? (1 << m_owner) : 0;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cred  = CREDITS;
        m_err   = 1'b0;
    endtask

    task automatic model_compare();
        chk("gnt",  int'(gnt),  m_gnt());
        chk("busy", int'(busy), (m_owner >= 0) ? 1 : 0);
        chk("fire", int'(fire), int'(m_fire_now()));
`ifdef OPA_CREDIT_EN
        chk("credits",  int'(credits),  m_cred);
        chk("cred_err", int'(cred_err), int'(m_err));
`endif
    endtask

    task automatic model_advance();
        bit f;
        bit found;
        int idx;
        f = m_fire_now();
        if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && req[idx]) begin
                    found   = 1'b1;
                    m_owner = idx;
                end
            end
        end else if (f && tail[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end
        if (f && !cur_ci) m_cred = m_cred - 1;
        else if (cur_ci && !f) begin
            if (m_cred == CREDITS) m_err = 1'b1;
            else m_cred = m_cred + 1;
        end
    endtask

    // One clock cycle: drive at negedge, check just after, model the edge.
    task automatic step(input logic [N-1:0] rq, input logic [N-1:0] tl,
                        input bit ci, input bit ordy);
        @(negedge clk);
        req  = rq;
        tail = tl;
`ifdef OPA_CREDIT_EN
        credit_in = ci;
        cur_ci    = ci;
        cur_ordy  = 1'b1;
`else
        out_ready = ordy;
        cur_ci    = 1'b0;
        cur_ordy  = ordy;
`endif
        #1;
        model_compare();
        model_advance();
    endtask

    // Reset asserted mid low-phase, away from any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        model_compare();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        cur_ci   = 1'b0;
        cur_ordy = 1'b1;
        model_reset();
        #1;
        model_compare();
        do_reset();

        // Basic grant and rotation
        step(5'b00101, 5'b11111, 0, 1);
        step(5'b00101, 5'b11111, 0, 1);
        chk("basic_gnt_c1", int'(gnt), 1);
        chk("basic_fire_c1", int'(fire), 1);
        step(5'b00101, 5'b11111, 0, 1);
        chk("basic_gnt_c2", int'(gnt), 0);
        step(5'b00101, 5'b11111, 0, 1);
        chk("basic_gnt_c3", int'(gnt), 4);
        step(5'b00000, 5'b00000, 0, 1);
        chk("basic_ptr3", m_ptr, 3);

        // Fairness: every requester served in turn, credit returned per fire
        do_reset();
        for (int c = 0; c < 12; c++) begin
            step(5'b11111, 5'b11111, (m_owner >= 0), 1);
            if (c % 2 == 1) chk("fair_gnt", int'(gnt), 1 << (((c - 1) / 2) % N));
            else            chk("fair_idle", int'(gnt), 0);
        end

        // Packet lock: req0 pauses mid-packet, req1 waits
        do_reset();
        step(5'b00011, 5'b00000, 0, 1);
        step(5'b00011, 5'b00000, 0, 1);
        chk("lock_fire1", int'(fire), 1);
        step(5'b00010, 5'b00000, 0, 1);
        chk("lock_gnt_hold", int'(gnt), 1);
        chk("lock_fire_pause", int'(fire), 0);
        step(5'b00011, 5'b00000, 0, 1);
        chk("lock_fire2", int'(fire), 1);
        step(5'b00011, 5'b00001, 0, 1);
        chk("lock_gnt4", int'(gnt), 1);
        step(5'b00010, 5'b00000, 0, 1);
        chk("lock_idle", int'(gnt), 0);
        step(5'b00010, 5'b00000, 0, 1);
        chk("lock_next", int'(gnt), 2);

`ifdef OPA_CREDIT_EN
        // Credit exhaustion on a 6-flit packet from req2
        do_reset();
        step(5'b00100, 5'b00000, 0, 1);
        for (int c = 1; c <= 4; c++) begin
            step(5'b00100, 5'b00000, 0, 1);
            chk("exh_fire", int'(fire), 1);
        end
        for (int c = 5; c <= 6; c++) begin
            step(5'b00100, 5'b00000, 0, 1);
            chk("exh_stall", int'(fire), 0);
            chk("exh_cred0", int'(credits), 0);
        end
        step(5'b00100, 5'b00000, 1, 1);
        chk("exh_ci_nofire", int'(fire), 0);
        step(5'b00100, 5'b00000, 0, 1);
        chk("exh_one_more", int'(fire), 1);
        step(5'b00100, 5'b00000, 0, 1);
        chk("exh_stall2", int'(fire), 0);
        step(5'b00100, 5'b00000, 1, 1);
        step(5'b00100, 5'b00100, 0, 1);
        chk("exh_tail", int'(fire), 1);
        step(5'b00000, 5'b00000, 0, 1);
        chk("exh_release", int'(gnt), 0);

        // Credit corner cases
        do_reset();
        step(5'b00001, 5'b00000, 0, 1);
        step(5'b00001, 5'b00000, 0, 1);
        step(5'b00001, 5'b00000, 0, 1);
        step(5'b00001, 5'b00000, 1, 1);
        chk("corner_cred2", int'(credits), 2);
        chk("corner_fire", int'(fire), 1);
        step(5'b00001, 5'b00001, 0, 1);
        chk("corner_cancel", int'(credits), 2);
        for (int c = 0; c < 4; c++) step(5'b00000, 5'b00000, 1, 1);
        step(5'b00000, 5'b00000, 0, 1);
        chk("corner_sat", int'(credits), 4);
        chk("corner_err", int'(cred_err), 1);
        for (int c = 0; c < 3; c++) step(5'b00000, 5'b00000, 0, 1);
        chk("corner_err_sticky", int'(cred_err), 1);
        do_reset();
        chk("corner_err_clr", int'(cred_err), 0);
`else
        // Transfers follow out_ready while the port is held
        do_reset();
        step(5'b00100, 5'b00000, 0, 1);
        for (int c = 0; c < 8; c++) begin
            bit o;
            o = ((8'b10110010 >> c) & 8'd1) != 0;
            step(5'b00100, 5'b00000, 0, o);
            chk("ordy_fire", int'(fire), int'(o));
            chk("ordy_gnt", int'(gnt), 4);
        end
        step(5'b00100, 5'b00100, 0, 1);
        chk("ordy_tail", int'(fire), 1);
        step(5'b00000, 5'b00000, 0, 1);
        chk("ordy_release", int'(gnt), 0);
`endif

        // Reset mid-packet, then arbitration restarts from ptr 0
        do_reset();
        step(5'b00100, 5'b00100, 0, 1);
        step(5'b00100, 5'b00100, 0, 1);
        step(5'b00001, 5'b00000, 0, 1);
        step(5'b00001, 5'b00000, 0, 1);
        step(5'b00001, 5'b00000, 0, 1);
        step(5'b00000, 5'b00000, 0, 1);
        chk("mid_gnt", int'(gnt), 1);
        chk("mid_busy", int'(busy), 1);
`ifdef OPA_CREDIT_EN
        chk("mid_cred1", int'(credits), 1);
`endif
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", int'(gnt), 0);
        chk("mid_rst_busy", int'(busy), 0);
`ifdef OPA_CREDIT_EN
        chk("mid_rst_cred", int'(credits), CREDITS);
`endif
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(5'b10010, 5'b00000, 0, 1);
        chk("restart_idle", int'(gnt), 0);
        step(5'b10010, 5'b00000, 0, 1);
        chk("restart_ptr0", int'(gnt), 2);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] rq;
            logic [N-1:0] tl;
            bit ci;
            bit ordy;
            if (c % 500 == 499) do_reset();
            rq   = N'($urandom) | N'($urandom);
            tl   = N'($urandom) & N'($urandom);
            ci   = ($urandom_range(0, 2) == 0);
            ordy = ($urandom_range(0, 3) != 0);
            step(rq, tl, ci, ordy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/noc_port_rr_arbiter.md
# noc_port_rr_arbiter

Round-robin, packet-locking arbiter for one router output port. It shares the port among N input-port requesters and holds the grant for the whole packet, head flit through tail flit. Downstream flow control uses a credit counter that tracks free slots in the next router's input buffer. It sits between the input-port routing logic and the output crossbar select in each router.

## Interface
Parameters:
- N, 5, number of requesting input ports.
- CREDITS, 4, downstream buffer depth. This is the credit counter's reset value.
- CW, 3, credit counter width. Must satisfy 2^CW > CREDITS.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N  requester i has a flit presented to this port.
- tail  in  N  the flit presented by requester i is a tail flit. Single-flit packets assert both req and tail.
- gnt  out  N  registered, one-hot or zero; current owner of the port; drives the crossbar select.
- fire  out  1  combinational; a flit transfers this cycle.
- busy  out  1  registered; the port is locked to an owner.
- credit_in  in  1  (OPA_CREDIT_EN only) downstream freed one slot.
- credits  out  CW  (OPA_CREDIT_EN only) registered free-slot count.
- cred_err  out  1  (OPA_CREDIT_EN only) sticky credit-overflow flag.
- out_ready  in  1  (without OPA_CREDIT_EN) downstream can accept a flit this cycle.

## Operation
- State machine has two states: IDLE and LOCKED. Pointer ptr is in [0, N-1].
- IDLE:
  - If req is non-zero, pick the winner: the first set req bit searching ptr, ptr+1, … mod N.
  - Next cycle: gnt = onehot(winner), busy = 1, state goes to LOCKED.
  - If req is zero, stay in IDLE with gnt = 0.
- LOCKED:
  - owner = index of the set gnt bit.
  - fire = req[owner] & can_send.
  - On fire with tail[owner] = 1: next cycle gnt = 0, busy = 0, state goes to IDLE, ptr = (owner+1) mod N.
  - On fire without tail: remain LOCKED.
  - If req[owner] = 0, hold the grant and keep fire = 0. A packet is never interrupted.
- Req and tail bits from non-owners are ignored while LOCKED.
- can_send = (credits != 0) with OPA_CREDIT_EN; can_send = out_ready without it.
- Credit counter (OPA_CREDIT_EN):
  - fire only: decrement.
  - credit_in only: increment.
  - Both in the same cycle: unchanged.
  - credit_in while credits == CREDITS and no fire: credits stay at CREDITS and cred_err is set to 1. cred_err clears only on rst.
  - fire is impossible at credits == 0, so the counter never underflows.
- The wrap-around of ptr from N-1 to 0 is required.

## Timing
- Reset values: state IDLE, ptr 0, gnt 0, busy 0, fire 0, credits CREDITS, cred_err 0.
- Reset takes effect immediately (asynchronous), including mid-packet. The in-flight packet is abandoned.
- req to gnt latency: 1 cycle. The first fire can occur in the first cycle gnt is high.
- Tail fire to gnt deassert: 1 cycle. There is exactly 1 IDLE cycle between packets, so the minimum packet-to-packet spacing is packet length + 1 cycles.
- fire is a combinational function of registered gnt, req, and can_send. There is no combinational path from req to gnt.
- The credits update is visible the cycle after fire or credit_in.

## Configuration
- OPA_CREDIT_EN defined:
  - Credit counter, credit_in, credits and cred_err are present.
  - can_send comes from the counter.
- OPA_CREDIT_EN undefined:
  - The counter and those three ports are removed.
  - out_ready input is present; can_send = out_ready.
  - All other behaviour is identical.

## Test plan
All scenarios use N=5, CREDITS=4, with OPA_CREDIT_EN unless noted.

- **Basic grant and rotation:** after reset, hold req=00101 with tail=11111.
  - Expect gnt=00001 at cycle 1 with fire=1, gnt=0 at cycle 2, then gnt=00100 at cycle 3.
  - ptr becomes 3.
- **Fairness:** hold req=11111 with tail=11111 and credit_in pulsed on every fire.
  - Expect gnt sequence 00001, 00010, 00100, 01000, 10000, 00001, one grant every 2 cycles.
- **Packet lock:**
  - Stimulus: req0 sends 3 flits with tail on the 3rd; req1 is held high throughout; req0 drops for 1 cycle mid-packet.
  - Expect gnt=00001 held for 4 cycles with 3 fires, then gnt=00010 after one IDLE cycle.
- **Credit exhaustion:** send a 6-flit packet from req2 with no credit_in.
  - Expect 4 fires, credits=0, fire=0 while stalled.
  - One credit_in yields exactly one more fire.
- **Credit corner cases:**
  - At credits=2, fire and credit_in in the same cycle: expect credits=2.
  - At credits=4, credit_in while idle: expect credits=4 and cred_err=1, held until rst.
- **Reset mid-packet:** assert rst asynchronously during LOCKED with credits=1.
  - Expect gnt=0, busy=0, credits=4 immediately.
  - After release, expect arbitration to restart from ptr 0.
  - Repeat without OPA_CREDIT_EN using out_ready toggling: expect fire to follow out_ready.
